// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate checker: op encodings, FSM state
// encoding and the truth-table function for every supported gate type.
package gate_check_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    // Encodings above this value (6, 7) are illegal.
    localparam logic [2:0] OP_LAST_LEGAL = OP_XOR;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

    // Expected gate output; illegal ops never reach a compare, return 0.
    function automatic logic expected_y(input logic [2:0] op, input logic a, input logic b);
        logic y;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_check_ref.sv
// Combinational reference model: maps a gate select and the two stimulus
// bits to the value a correct gate would produce.
module gate_check_ref
    import gate_check_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    // Pure truth-table lookup.
    always_comb begin
        y = expected_y(op, a, b);
    end

endmodule

// File: rtl/gate_checker.sv
// Gate exerciser: drives every truth-table vector for the selected gate,
// waits SETTLE_CYCLES, samples dut_y and accumulates a fail mask/count.
// Optional build macro GATE_CHECK_STOP_ON_FAIL_EN: end the run at the
// first mismatching vector instead of exercising all vectors.
// Handshake: start is a one-cycle request honoured only while idle; done is
// a one-cycle pulse and pass/err_count/fail_mask hold until the next start.
module gate_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic       illegal_op,
    output state_t     state_dbg
);

    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [3:0] SETTLE_LAST = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic [1:0] vec;
    logic [3:0] settle_cnt;
    logic       pass_q;
    logic       exp_y;
    logic       mismatch;
    logic       last_vec;

    gate_check_ref u_ref (
        .op (op_q),
        .a  (drv_a),
        .b  (drv_b),
        .y  (exp_y)
    );

    assign mismatch  = (dut_y != exp_y);
    // NOT only walks vectors 0 and 2, so its last vector is 2.
    assign last_vec  = (op_q == OP_NOT) ? (vec == 2'd2) : (vec == 2'd3);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = op_is_illegal(op) ? ST_FINISH : ST_DRIVE;
            end
            ST_DRIVE:  state_nxt = HAS_SETTLE ? ST_SETTLE : ST_CHECK;
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                if (mismatch || last_vec) state_nxt = ST_FINISH;
                else                      state_nxt = ST_DRIVE;
`else
                if (last_vec) state_nxt = ST_FINISH;
                else          state_nxt = ST_DRIVE;
`endif
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state; pass is live during done, then held.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_FINISH);
        pass = done ? ((err_count == 3'd0) && !illegal_op) : pass_q;
    end

    // Run datapath: op capture, vector drive, settle count, result tally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_AND;
            vec        <= 2'd0;
            settle_cnt <= 4'd0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            err_count  <= 3'd0;
            fail_mask  <= 4'd0;
            illegal_op <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        vec        <= 2'd0;
                        err_count  <= 3'd0;
                        fail_mask  <= 4'd0;
                        pass_q     <= 1'b0;
                        illegal_op <= op_is_illegal(op);
                    end
                end
                ST_DRIVE: begin
                    drv_a      <= vec[1];
                    drv_b      <= vec[0];
                    settle_cnt <= 4'd0;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count      <= err_count + 3'd1;
                        fail_mask[vec] <= 1'b1;
                    end
                    vec <= (op_q == OP_NOT) ? vec + 2'd2 : vec + 2'd1;
                end
                ST_FINISH: pass_q <= (err_count == 3'd0) && !illegal_op;
                default: ;
            endcase
        end
    end

endmodule
